// File: rtl/glitch_clkgen_pkg.sv
// glitch_clkgen_pkg: shared FSM state type and default field widths for the glitch clock generator.
package glitch_clkgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_GLITCH = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int DEF_DIV_WIDTH = 8;
    localparam int DEF_DLY_WIDTH = 16;

endpackage

// File: rtl/glitch_clkgen_phase_counter.sv
// clkgen_phase_counter: counts clk cycles of the current target-clock phase and strobes when it ends.
module clkgen_phase_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tick
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    // The phase ends on the cycle the count reaches term-1; term is always at least 1.
    assign tick = en && (cnt_q >= term - ONE);

    // Next count: cleared while parked and at each phase end, otherwise advances.
    always_comb begin
        cnt_d = (!en || tick) ? '0 : cnt_q + ONE;
    end

    // Phase count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/glitch_clkgen.sv
// glitch_clkgen: divided target clock with one schedulable shortened high phase.
// Optional macro GLITCH_CLKGEN_EDGECNT_EN adds io_edge_count, a wrapping count of rising toggles.
module glitch_clkgen
    import glitch_clkgen_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH,
    parameter int DLY_WIDTH = DEF_DLY_WIDTH
) (
    input  logic                 clk,
    input  logic                 io_reset_n,
    input  logic                 io_run,
    input  logic [DIV_WIDTH-1:0] io_half_period,
    input  logic                 io_arm,
    input  logic [DLY_WIDTH-1:0] io_glitch_delay,
    input  logic [DIV_WIDTH-1:0] io_glitch_len,
    output logic                 io_target_clk,
    output logic                 io_busy,
`ifdef GLITCH_CLKGEN_EDGECNT_EN
    output logic [DLY_WIDTH-1:0] io_edge_count,
`endif
    output logic                 io_glitch_done
);

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [DLY_WIDTH-1:0] DLY_ONE = DLY_WIDTH'(1);

    state_e               state_q, state_d;
    logic                 clk_q, clk_d;
    logic [DIV_WIDTH-1:0] term_q, term_d;
    logic [DIV_WIDTH-1:0] len_q, len_d;
    logic [DLY_WIDTH-1:0] dly_q, dly_d;
    logic [DLY_WIDTH-1:0] ecnt_q, ecnt_d;
    logic [DIV_WIDTH-1:0] h_eff, l_eff, cur_term;
    logic                 tick, rise, fall, hit;

    // Zero lengths behave as one cycle.
    assign h_eff = (io_half_period == '0) ? DIV_ONE : io_half_period;
    assign l_eff = (io_glitch_len == '0) ? DIV_ONE : io_glitch_len;

    // term_q of zero means no phase length sampled yet (first phase after run), so follow the live input.
    assign cur_term = (term_q == '0) ? h_eff : term_q;

    assign rise = tick && !clk_q;
    assign fall = tick && clk_q;
    assign hit  = (state_q == ST_ARMED) && rise && (ecnt_q == dly_q);

    clkgen_phase_counter #(
        .W(DIV_WIDTH)
    ) u_phase (
        .clk   (clk),
        .rst_n (io_reset_n),
        .en    (io_run),
        .term  (cur_term),
        .tick  (tick)
    );

    // Glitch scheduling FSM plus target clock level and next-phase length selection.
    always_comb begin
        state_d = state_q;
        clk_d   = tick ? ~clk_q : clk_q;
        term_d  = tick ? (hit ? len_q : h_eff) : term_q;
        len_d   = len_q;
        dly_d   = dly_q;
        ecnt_d  = ecnt_q;
        case (state_q)
            ST_IDLE: begin
                if (io_arm && io_run) begin
                    dly_d   = io_glitch_delay;
                    len_d   = l_eff;
                    ecnt_d  = '0;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (rise) begin
                    state_d = hit ? ST_GLITCH : ST_ARMED;
                    ecnt_d  = hit ? ecnt_q : ecnt_q + DLY_ONE;
                end
            end
            ST_GLITCH: state_d = fall ? ST_DONE : ST_GLITCH;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (!io_run) begin
            state_d = ST_IDLE;
            clk_d   = 1'b0;
            term_d  = '0;
        end
    end

    // State, clock level and latched glitch parameters.
    always_ff @(posedge clk or negedge io_reset_n) begin
        if (!io_reset_n) begin
            state_q <= ST_IDLE;
            clk_q   <= 1'b0;
            term_q  <= '0;
            len_q   <= '0;
            dly_q   <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            clk_q   <= clk_d;
            term_q  <= term_d;
            len_q   <= len_d;
            dly_q   <= dly_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign io_target_clk  = clk_q;
    assign io_busy        = (state_q == ST_ARMED) || (state_q == ST_GLITCH);
    assign io_glitch_done = (state_q == ST_DONE);

`ifdef GLITCH_CLKGEN_EDGECNT_EN
    logic [DLY_WIDTH-1:0] edges_q, edges_d;

    // Rising toggles since reset; nothing toggles while parked, so the count holds.
    always_comb begin
        edges_d = rise ? edges_q + DLY_ONE : edges_q;
    end

    // Edge count register.
    always_ff @(posedge clk or negedge io_reset_n) begin
        if (!io_reset_n) begin
            edges_q <= '0;
        end else begin
            edges_q <= edges_d;
        end
    end

    assign io_edge_count = edges_q;
`endif

endmodule

// File: tb/tb_glitch_clkgen.sv
// tb_glitch_clkgen: table, hand-sequence and randomized model checks for glitch_clkgen.
module tb_glitch_clkgen;

    localparam int DW = 8;
    localparam int LW = 4;

    typedef struct {
        int h;
        int dly;
        int len;
        int a;
        int exp_g;
        int exp_done;
    } vec_t;

    logic          clk = 1'b0;
    logic          io_reset_n;
    logic          io_run;
    logic [DW-1:0] io_half_period;
    logic          io_arm;
    logic [LW-1:0] io_glitch_delay;
    logic [DW-1:0] io_glitch_len;
    logic          io_target_clk;
    logic          io_busy;
    logic          io_glitch_done;
`ifdef GLITCH_CLKGEN_EDGECNT_EN
    logic [LW-1:0] io_edge_count;
`endif

    int errors = 0;
    int checks = 0;
    int exp_clk[0:255];
    int exp_busy[0:255];
    int exp_done[0:255];
    int m_fall;
    vec_t vecs[6];

    glitch_clkgen #(
        .DIV_WIDTH(DW),
        .DLY_WIDTH(LW)
    ) dut (
        .clk             (clk),
        .io_reset_n      (io_reset_n),
        .io_run          (io_run),
        .io_half_period  (io_half_period),
        .io_arm          (io_arm),
        .io_glitch_delay (io_glitch_delay),
        .io_glitch_len   (io_glitch_len),
        .io_target_clk   (io_target_clk),
        .io_busy         (io_busy),
`ifdef GLITCH_CLKGEN_EDGECNT_EN
        .io_edge_count   (io_edge_count),
`endif
        .io_glitch_done  (io_glitch_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        io_reset_n = 1'b0;
        io_run     = 1'b0;
        io_arm     = 1'b0;
        repeat (2) @(posedge clk);
        #1 io_reset_n = 1'b1;
    endtask

    // Expected waveform from phase arithmetic: output values after each edge t, run high from edge 1.
    task automatic build_model(input int h, input int a, input int dly, input int ln, input int n);
        int he, le, pos, lvl, plen, rises, g_rise, e;
        he = (h == 0) ? 1 : h;
        le = (ln == 0) ? 1 : ln;
        pos = 0; lvl = 0; plen = he; rises = 0; g_rise = -1; m_fall = -1;
        for (int t = 0; t <= n; t++) begin
            exp_clk[t] = 0; exp_busy[t] = 0; exp_done[t] = 0;
        end
        while (pos < n) begin
            e = pos + plen;
            for (int t = pos + 1; t <= n && t < e; t++) exp_clk[t] = lvl;
            lvl = 1 - lvl;
            if (e <= n) exp_clk[e] = lvl;
            plen = he;
            if (lvl == 1 && g_rise < 0 && e > a) begin
                if (rises == dly) begin
                    g_rise = e;
                    plen = le;
                end else begin
                    rises++;
                end
            end else if (lvl == 0 && g_rise >= 0 && m_fall < 0) begin
                m_fall = e;
            end
            pos = e;
        end
        for (int t = a; t <= n && (m_fall < 0 || t < m_fall); t++) exp_busy[t] = 1;
        if (m_fall >= 0 && m_fall <= n) exp_done[m_fall] = 1;
    endtask

    task automatic run_row(input vec_t v, output int g, output int d, output int b);
        int prev;
        do_reset();
        io_half_period  = DW'(v.h);
        io_glitch_delay = LW'(v.dly);
        io_glitch_len   = DW'(v.len);
        io_run = 1'b1;
        prev = 0; g = -1; d = -1; b = -1;
        for (int t = 1; t <= 300 && d < 0; t++) begin
            io_arm = (t == v.a);
            tick_cycle();
            if (io_target_clk && prev == 0) g = t;
            if (io_glitch_done) begin
                d = t;
                b = int'(io_busy);
            end
            prev = int'(io_target_clk);
        end
        io_arm = 1'b0;
    endtask

    initial begin
        int g, d, b, dn, bz;
        vecs[0] = '{4, 3, 1, 1, 28, 29};
        vecs[1] = '{2, 0, 0, 1, 2, 3};
        vecs[2] = '{0, 2, 3, 2, 7, 10};
        vecs[3] = '{3, 1, 5, 3, 15, 20};
        vecs[4] = '{5, 0, 2, 4, 5, 7};
        vecs[5] = '{1, 4, 1, 5, 15, 16};

        io_reset_n = 1'b0; io_run = 1'b0; io_arm = 1'b0;
        io_half_period = '0; io_glitch_delay = '0; io_glitch_len = '0;
        #1;
        check("reset_clk", int'(io_target_clk), 0);
        check("reset_busy", int'(io_busy), 0);
        check("reset_done", int'(io_glitch_done), 0);

        // Free-running H=4: period 8, 50% duty, never busy.
        do_reset();
        io_half_period = 8'd4;
        io_run = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick_cycle();
            check("free_run_clk", int'(io_target_clk), (t / 4) % 2);
            check("free_run_busy", int'(io_busy), 0);
        end

        // Table of single glitches: glitched rise cycle, done cycle, busy at done.
        for (int i = 0; i < 6; i++) begin
            run_row(vecs[i], g, d, b);
            check($sformatf("row%0d_glitch_rise", i), g, vecs[i].exp_g);
            check($sformatf("row%0d_done_cycle", i), d, vecs[i].exp_done);
            check($sformatf("row%0d_busy_at_done", i), b, 0);
        end

        // Re-arm while busy is ignored; dropping run aborts without a done pulse.
        do_reset();
        io_half_period = 8'd4;
        io_run = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            io_arm = (t == 2) || (t == 6);
            io_glitch_delay = (t == 2) ? 4'd5 : 4'd0;
            io_glitch_len   = (t == 2) ? 8'd2 : 8'd1;
            if (t == 14) io_run = 1'b0;
            tick_cycle();
            if (t == 13) begin
                check("rearm_ignored_clk", int'(io_target_clk), 1);
                check("rearm_busy", int'(io_busy), 1);
            end
        end
        io_arm = 1'b0;
        check("abort_clk_low", int'(io_target_clk), 0);
        check("abort_busy", int'(io_busy), 0);
        dn = 0; bz = 0;
        for (int t = 0; t < 20; t++) begin
            tick_cycle();
            dn += int'(io_glitch_done);
            bz += int'(io_busy);
        end
        check("abort_no_done", dn, 0);
        check("abort_busy_stays_low", bz, 0);

        // Asynchronous reset during the glitched high phase, then restart with H=3.
        do_reset();
        io_half_period = 8'd2; io_glitch_delay = 4'd0; io_glitch_len = 8'd8;
        io_run = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            io_arm = (t == 1);
            tick_cycle();
        end
        io_arm = 1'b0;
        check("pre_reset_busy", int'(io_busy), 1);
        check("pre_reset_clk", int'(io_target_clk), 1);
        #2 io_reset_n = 1'b0;
        #1;
        check("async_reset_clk", int'(io_target_clk), 0);
        check("async_reset_busy", int'(io_busy), 0);
        check("async_reset_done", int'(io_glitch_done), 0);
        io_half_period = 8'd3;
        @(negedge clk);
        io_reset_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick_cycle();
            check($sformatf("restart_clk_edge%0d", k), int'(io_target_clk), (k == 3) ? 1 : 0);
        end

`ifdef GLITCH_CLKGEN_EDGECNT_EN
        // 17 rising toggles wrap a 4-bit edge count to 1, and it holds while parked.
        do_reset();
        io_half_period = 8'd1;
        io_run = 1'b1;
        repeat (33) tick_cycle();
        check("edge_count_wrap", int'(io_edge_count), 1);
        io_run = 1'b0;
        repeat (5) tick_cycle();
        check("edge_count_hold", int'(io_edge_count), 1);
`endif

        // Randomized single-glitch runs against the phase-arithmetic model.
        for (int it = 0; it < 12; it++) begin
            int h, dly, ln, a, n;
            h   = int'($urandom_range(0, 5));
            dly = int'($urandom_range(0, 4));
            ln  = int'($urandom_range(0, 6));
            a   = int'($urandom_range(1, 12));
            n   = a + (dly + 2) * 2 * ((h == 0) ? 1 : h) + ln + 6;
            build_model(h, a, dly, ln, n);
            do_reset();
            io_half_period = DW'(h);
            io_run = 1'b1;
            for (int t = 1; t <= n; t++) begin
                io_arm = (t == a) || (t > a && t <= m_fall && $urandom_range(0, 3) == 0);
                io_glitch_delay = (t == a) ? LW'(dly) : LW'($urandom);
                io_glitch_len   = (t == a) ? DW'(ln) : DW'($urandom);
                tick_cycle();
                check("rand_clk", int'(io_target_clk), exp_clk[t]);
                check("rand_busy", int'(io_busy), exp_busy[t]);
                check("rand_done", int'(io_glitch_done), exp_done[t]);
            end
            io_arm = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
